// File: rtl/fetch_unit.sv
// LITE-16 instruction fetch stage: owns the PC, reads the same-cycle ROM and
// buffers {pc, instr} pairs in a two-entry prefetch queue toward decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    input  logic        halt,
    output logic        busy
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [15:0] pc_reg;
    logic [15:0] slot_pc_reg    [2];
    logic [15:0] slot_instr_reg [2];
    logic [1:0]  count_reg;
    logic        pop;
    logic        push;

    assign pop  = out_valid & out_ready;
    assign push = !halt & !redirect_valid & ((count_reg < FULL) | pop);

    // Slot 0 is the head; it is only overwritten by a newer entry, so an
    // emptied queue keeps presenting the last dequeued pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            count_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                slot_pc_reg[i]    <= 16'h0000;
                slot_instr_reg[i] <= 16'h0000;
            end
        end else if (redirect_valid) begin
            count_reg <= 2'd0;
            pc_reg    <= redirect_addr;
        end else begin
            if (push) begin
                pc_reg <= pc_reg + 16'd1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        slot_pc_reg[0]    <= pc_reg;
                        slot_instr_reg[0] <= rom_data;
                    end else begin
                        slot_pc_reg[1]    <= pc_reg;
                        slot_instr_reg[1] <= rom_data;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    if (count_reg == FULL) begin
                        slot_pc_reg[0]    <= slot_pc_reg[1];
                        slot_instr_reg[0] <= slot_instr_reg[1];
                    end
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == FULL) begin
                        slot_pc_reg[0]    <= slot_pc_reg[1];
                        slot_instr_reg[0] <= slot_instr_reg[1];
                        slot_pc_reg[1]    <= pc_reg;
                        slot_instr_reg[1] <= rom_data;
                    end else begin
                        slot_pc_reg[0]    <= pc_reg;
                        slot_instr_reg[0] <= rom_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr  = pc_reg;
    assign out_valid = (count_reg != 2'd0);
    assign out_pc    = slot_pc_reg[0];
    assign out_instr = slot_instr_reg[0];
    assign busy      = out_valid | !halt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random run scored against a
// queue-based model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        halt = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [15:0] m_pc;

    fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .halt(halt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    assign rom_data = rom(rom_addr);

    // Advance one clock: model applies the inputs currently driven, then the
    // bench lands on the following falling edge.
    task automatic step();
        bit pop, push;
        if (!rst_n) begin
            m_q.delete();
            m_pc = 16'h0000;
        end else begin
            pop  = (m_q.size() != 0) && out_ready;
            push = !halt && !redirect_valid && ((m_q.size() < 2) || pop);
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_addr;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back({m_pc, rom(m_pc)});
                    m_pc = m_pc + 16'd1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; out_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; out_ready = 1'b1; halt = 1'b0;
        #1;
        checks++;
        if (rom_addr !== 16'h0000 || out_valid !== 1'b0 || out_pc !== 16'h0000 ||
            out_instr !== 16'h0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: addr=%h valid=%b pc=%h instr=%h busy=%b want 0000/0/0000/0000/1",
                     rom_addr, out_valid, out_pc, out_instr, busy);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_instr !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL reset_stream[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h",
                         i, out_valid, out_pc, out_instr, 16'(i), 16'h1000 + 16'(i));
            end
            $display("reset_stream[%0d] pc=%h instr=%h", i, out_pc, out_instr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || rom_addr !== 16'h0002 || out_pc !== 16'h0000) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: valid=%b addr=%h pc=%h want 1/0002/0000",
                             i, out_valid, rom_addr, out_pc);
                end
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_instr !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL bp_drain[%0d]: valid=%b pc=%h instr=%h want 1/%h",
                         i, out_valid, out_pc, out_instr, 16'(i));
            end
            $display("bp_drain[%0d] pc=%h", i, out_pc);
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (rom_addr !== 16'h0005) begin
            errors++;
            $display("FAIL redir_pre: addr=%h want 0005", rom_addr);
        end
        redirect_valid = 1'b1; redirect_addr = 16'h0010;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 16'h0010) begin
            errors++;
            $display("FAIL redir_flush: valid=%b addr=%h want 0/0010", out_valid, rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'h0010 + 16'(i) ||
                out_instr !== 16'h1010 + 16'(i)) begin
                errors++;
                $display("FAIL redir_stream[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h",
                         i, out_valid, out_pc, out_instr, 16'h0010 + 16'(i), 16'h1010 + 16'(i));
            end
            $display("redir_stream[%0d] pc=%h instr=%h", i, out_pc, out_instr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        out_ready = 1'b0;
        step(); step();
        halt = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || out_pc !== 16'h0000) begin
            errors++;
            $display("FAIL halt_full: busy=%b pc=%h want 1/0000", busy, out_pc);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0001) begin
            errors++;
            $display("FAIL halt_drain: valid=%b pc=%h want 1/0001", out_valid, out_pc);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 16'h0002 || busy !== 1'b0 || out_pc !== 16'h0001) begin
            errors++;
            $display("FAIL halt_empty: valid=%b addr=%h busy=%b pc=%h want 0/0002/0/0001",
                     out_valid, rom_addr, busy, out_pc);
        end
        halt = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0002 || out_instr !== 16'h1002) begin
            errors++;
            $display("FAIL halt_resume: valid=%b pc=%h instr=%h want 1/0002/1002",
                     out_valid, out_pc, out_instr);
        end
        halt = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0030;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 16'h0030) begin
            errors++;
            $display("FAIL halt_redir: valid=%b addr=%h want 0/0030", out_valid, rom_addr);
        end
        halt = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0030) begin
            errors++;
            $display("FAIL halt_redir_resume: valid=%b pc=%h want 1/0030", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [4];
        exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        out_ready = 1'b1; halt = 1'b0;
        redirect_valid = 1'b1; redirect_addr = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== rom(exp_pc[i])) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h",
                         i, out_valid, out_pc, out_instr, exp_pc[i], rom(exp_pc[i]));
            end
            $display("wrap[%0d] pc=%h", i, out_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: valid=%b addr=%h want 0/0000", out_valid, rom_addr);
        end
        m_q.delete();
        m_pc = 16'h0000;
        @(negedge clk);
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            checks++;
            if (out_valid !== (m_q.size() != 0) || rom_addr !== m_pc ||
                busy !== ((m_q.size() != 0) || !halt) ||
                (m_q.size() != 0 && {out_pc, out_instr} !== m_q[0])) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b addr=%h pc=%h instr=%h busy=%b want valid=%b addr=%h head=%h",
                         n, out_valid, rom_addr, out_pc, out_instr, busy,
                         m_q.size() != 0, m_pc, (m_q.size() != 0) ? m_q[0] : 32'h0);
            end
            out_ready      = ($urandom_range(2, 0) != 0);
            halt           = ($urandom_range(4, 0) == 0);
            redirect_valid = ($urandom_range(9, 0) == 0);
            redirect_addr  = ($urandom_range(1, 0) != 0) ? 16'(16'hFFF8 + $urandom_range(7, 0))
                                                         : 16'($urandom);
            step();
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        m_pc = 16'h0000;
        test_reset();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the LITE-16 core, directly upstream of the combinational program ROM (16-bit address in, 16-bit word out, same-cycle read). Owns the program counter, drives the ROM address and captures returned words into a 2-entry prefetch queue. Presents {pc, instr} pairs to the decode stage over a valid/ready handshake. Supports branch redirect with flush, and a fetch halt.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
DEPTH, 2, prefetch queue entries (fixed at 2; other values not supported)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rom_addr  out  16  address to ROM, always equal to the PC register
rom_data  in  16  ROM word for rom_addr, valid in the same cycle
out_valid  out  1  queue head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  16  head instruction word
out_pc  out  16  address the head word was fetched from
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_addr  in  16  new PC on redirect
halt  in  1  level: suppress new fetches while high
busy  out  1  high when queue non-empty or fetch enabled (not halted)

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0; rom_addr=RESET_PC immediately. Deassertion is taken synchronously; first push on the first rising edge with rst_n high.
- pop = out_valid & out_ready. Head entry retired on that edge.
- push = !halt & !redirect_valid & (count<2 | pop). On push: enqueue {pc, rom_data}, pc <= pc+1.
- Full queue with simultaneous pop: push and pop both occur; count stays 2; order preserved.
- Full queue, no pop: no push, pc holds, rom_addr stable.
- PC increment is modulo 2^16: 16'hFFFF -> 16'h0000, no flag.
- Redirect (highest priority): on edge with redirect_valid=1, queue cleared (count=0), pc <= redirect_addr, no push that cycle regardless of halt or space. A pop occurring the same cycle is still considered accepted by decode; the entry is discarded by the flush. Next cycle out_valid=0; first word from redirect_addr is pushed on the following edge (redirect-to-valid latency 2 edges).
- Redirect while halt=1: pc updated, queue cleared, no fetch until halt falls.
- Halt: no pushes; queued entries still drain normally; pc holds. Release resumes fetch from held pc on next edge.
- out_valid = (count!=0); out_instr/out_pc show head; when empty they hold last-dequeued values (not X).
- busy = out_valid | !halt.
- Fetch-to-decode latency: word read at PC appears at out_* one edge after the edge with rom_addr=PC (registered queue, no bypass).
- Throughput: 1 instruction/cycle sustained when out_ready held high.

Test Plan:
- Reset: ROM word[i]=16'h1000+i, rst_n low then high with out_ready=1 -> rom_addr=0 during reset, out_valid=0; after first edge out_pc=0,out_instr=16'h1000; subsequent cycles 0x1001,0x1002,... one per cycle.
- Backpressure: out_ready=0 for 5 cycles from reset -> queue fills after 2 edges, rom_addr holds 2, out_pc stays 0; raise out_ready -> pcs 0,1,2,3 in order, no gaps or duplicates.
- Redirect: during streaming at pc=5 assert redirect_valid with redirect_addr=16'h0010 for 1 cycle -> next cycle out_valid=0; following cycle out_pc=16'h0010, out_instr=16'h1010; no instruction from pcs 4..6 appears after the redirect.
- Halt: halt=1 with 2 entries queued, out_ready=1 -> 2 entries drain, out_valid=0, rom_addr constant, busy=0; halt=0 -> fetch resumes at held pc.
- Wrap: redirect to 16'hFFFE -> out_pc sequence FFFE, FFFF, 0000, 0001.
- Async reset mid-stream: pull rst_n low between edges with full queue -> out_valid=0 and rom_addr=RESET_PC immediately, without waiting for a clock edge.
